sec32_check_encoder: RTL and testbench
======================================

// Module: sec32_check_encoder
// PURPOSE
// - Transmit-side companion of the c499 32-bit SEC corrector: computes the 8 check bits that the
//   c499 decoder consumes (N129..N136, with N137=1), so a clean codeword gives a zero syndrome.
// - Registered valid/ready stream with an output FIFO. Single-bit error injection lets benches
//   exercise the downstream corrector.
// PARAMETERS
// - FIFO_DEPTH  2   output buffer entries (>=2); full throughput at depth>=2
// - CNT_W       16  width of word counter
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - in_valid     in   1   input word valid
// - in_ready     out  1   encoder can accept (FIFO not full)
// - in_data      in   32  data d[31:0]; d[i] maps to decoder input N(1+4i)
// - out_valid    out  1   codeword available (FIFO not empty)
// - out_ready    in   1   downstream accepts codeword
// - out_data     out  32  data field (after optional injection)
// - out_check    out  8   check c[7:0]; c[k] maps to decoder input N(129+k)
// - inj_arm      in   1   1-cycle pulse: corrupt next accepted word
// - inj_pos      in   6   bit to flip: 0..31 = out_data[pos], 32..39 = out_check[pos-32]
// - inj_pending  out  1   injection armed, not yet applied
// - word_cnt     out  CNT_W  codewords popped (out_valid & out_ready), wraps to 0
// BEHAVIOUR
// - Check equations (^ = XOR reduction):
//   c0=^{d0,d4,d8,d12,d16..d23}  c1=^{d1,d5,d9,d13,d24..d31}
//   c2=^{d2,d6,d10,d14,d16..d19,d24..d27}  c3=^{d3,d7,d11,d15,d20..d23,d28..d31}
//   c4=^{d0..d7,d16,d20,d24,d28}  c5=^{d8..d15,d17,d21,d25,d29}
//   c6=^{d0..d3,d8..d11,d18,d22,d26,d30}  c7=^{d4..d7,d12..d15,d19,d23,d27,d31}
// - Accept when in_valid & in_ready. {in_data, check} are computed combinationally and pushed
//   into the FIFO in the same edge.
// - Latency: a word accepted at edge N is on out_* after edge N (1 cycle) when the FIFO was empty.
// - FIFO: count 0..FIFO_DEPTH. in_ready = (count != FIFO_DEPTH), registered-state only; it does
//   not depend on out_ready. Push and pop in the same cycle: count unchanged, order preserved.
//   Pop when out_valid & out_ready. out_* holds stable while out_valid & !out_ready.
// - Injection FSM, states IDLE/ARMED:
//   - IDLE --inj_arm & inj_pos<40--> ARMED, latch inj_pos. inj_arm with inj_pos>=40 is ignored.
//   - ARMED --accept--> IDLE. The latched bit is flipped in the pushed entry only; computed
//     check bits stay based on the clean data.
//   - inj_arm while ARMED: pos is re-latched, stays ARMED.
//   - inj_arm and accept in the same cycle while IDLE: this word is not corrupted; arm for the next.
//   - inj_pending = (state==ARMED).
// - word_cnt increments by 1 per pop; it wraps from 2^CNT_W-1 to 0.
// - Reset (async assert, sync deassert handled upstream): FIFO flushed, count=0, state=IDLE.
//   Outputs: in_ready=1, out_valid=0, out_data=0, out_check=0, inj_pending=0, word_cnt=0.
//   Reset mid-stream drops all buffered words, and no partial codeword is emitted.
// TESTING
// - in_data=0x00000001, out_ready=1 -> out_check=0x51 one cycle later, out_data=0x00000001
// - in_data=0x00010000 -> out_check=0x15; in_data=0xFFFFFFFF -> out_check=0x00; 0x0 -> 0x00
// - Hold out_ready=0 and offer 3 words -> in_ready drops after 2 accepts. Then raise out_ready
//   -> words emerge in order, word_cnt=3.
// - inj_arm with inj_pos=5, send 0x0 -> out_data=0x00000020, out_check=0x00, and inj_pending is
//   cleared. With pos=33 -> out_check=0x02. With pos=45 -> ignored, inj_pending stays 0.
// - Continuous valid with out_ready=1 for 100 words -> one word per cycle, no bubbles. Feed to
//   c499 (N137=1): outputs equal inputs, and with pos<32 injected the decoder corrects the word.
// - Assert rst_n=0 with 2 entries queued -> out_valid=0 and in_ready=1 immediately, word_cnt=0.

Source files
------------

// File: rtl/sec32_check_encoder.sv
// Check-bit encoder for the c499 32-bit SEC corrector: computes the 8 check bits for each data word,
// buffers codewords in a small output FIFO and can flip one chosen bit of a codeword for error injection.
module sec32_check_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    input  logic             inj_arm,
    input  logic [5:0]       inj_pos,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt
);

    // Handshake: a word transfers on any rising edge where valid and ready are both high.
    // in_ready is driven from registered FIFO state only. out_* holds stable while out_valid is high and out_ready is low.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, ARMED} inj_state_t;

    function automatic logic [7:0] calc_check(input logic [31:0] d);
        logic [7:0] c;
        c[0] = ^{d[0], d[4], d[8],  d[12], d[23:16]};
        c[1] = ^{d[1], d[5], d[9],  d[13], d[31:24]};
        c[2] = ^{d[2], d[6], d[10], d[14], d[19:16], d[27:24]};
        c[3] = ^{d[3], d[7], d[11], d[15], d[23:20], d[31:28]};
        c[4] = ^{d[7:0],  d[16], d[20], d[24], d[28]};
        c[5] = ^{d[15:8], d[17], d[21], d[25], d[29]};
        c[6] = ^{d[3:0],  d[11:8],  d[18], d[22], d[26], d[30]};
        c[7] = ^{d[7:4],  d[15:12], d[19], d[23], d[27], d[31]};
        return c;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [39:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    inj_state_t    state;
    logic [5:0]    pos_q;

    logic          accept;
    logic          pop;
    logic [39:0]   clean_entry;
    logic [39:0]   flip_mask;
    logic [39:0]   push_entry;

    assign in_ready    = (count != CW'(FIFO_DEPTH));
    assign out_valid   = (count != '0);
    assign accept      = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign out_data    = mem[rd_ptr][31:0];
    assign out_check   = mem[rd_ptr][39:32];
    assign inj_pending = (state == ARMED);

    // Entry layout {check, data} makes inj_pos a direct bit index into it.
    assign clean_entry = {calc_check(in_data), in_data};
    assign flip_mask   = (state == ARMED) ? (40'd1 << pos_q) : 40'd0;
    assign push_entry  = clean_entry ^ flip_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh arm wins over the accept that consumes an earlier arm, so it targets the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pos_q <= '0;
        end else if (inj_arm && (inj_pos < 6'd40)) begin
            state <= ARMED;
            pos_q <= inj_pos;
        end else if ((state == ARMED) && accept) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_cnt <= '0;
        else if (pop) word_cnt <= word_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_sec32_check_encoder.sv
// Directed bench for sec32_check_encoder: hand-computed check bytes, backpressure, injection,
// a 100-word stream through a corrector model, counter wrap and mid-stream reset.
module tb_sec32_check_encoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [7:0]       out_check;
    logic             inj_arm;
    logic [5:0]       inj_pos;
    logic             inj_pending;
    logic [CNT_W-1:0] word_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;
    logic [71:0] exp_q[$];

    sec32_check_encoder #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_check(out_check),
        .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_pending(inj_pending),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Reference check bits from per-bit column masks derived by hand from the equations.
    function automatic logic [7:0] ref_check(input logic [31:0] d);
        logic [31:0] m [8];
        logic [7:0]  c;
        m[0] = 32'h00FF1111; m[1] = 32'hFF002222;
        m[2] = 32'h0F0F4444; m[3] = 32'hF0F08888;
        m[4] = 32'h111100FF; m[5] = 32'h2222FF00;
        m[6] = 32'h44440F0F; m[7] = 32'h8888F0F0;
        for (int k = 0; k < 8; k++) c[k] = ^(d & m[k]);
        return c;
    endfunction

    // Single-error corrector model: a data-bit error yields a syndrome equal to that bit's column.
    function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  syn;
        logic [31:0] r;
        syn = c ^ ref_check(d);
        r   = d;
        for (int i = 0; i < 32; i++)
            if (syn != 8'h00 && ref_check(32'd1 << i) == syn) r[i] = ~r[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag);
        check(tag, 64'(word_cnt), 64'(exp_cnt % (1 << CNT_W)));
    endtask

    // Offer one word with out_ready=1, check the codeword one cycle later and that it drains.
    task automatic send_check(input string tag, input logic [31:0] d,
                              input logic [31:0] exp_d, input logic [7:0] exp_c);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(exp_d));
        check({tag, "_check"}, 64'(out_check), 64'(exp_c));
        @(negedge clk);
        exp_cnt++;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
        check_cnt({tag, "_cnt"});
    endtask

    initial begin
        logic [71:0] ent;
        logic [31:0] d;
        logic [31:0] ed;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inj_arm   = 1'b0;
        inj_pos   = '0;
        #1;
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_out_data",  64'(out_data),    64'd0);
        check("rst_out_check", 64'(out_check),   64'd0);
        check("rst_pending",   64'(inj_pending), 64'd0);
        check("rst_word_cnt",  64'(word_cnt),    64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send_check("d0001", 32'h00000001, 32'h00000001, 8'h51);
        send_check("d10000", 32'h00010000, 32'h00010000, 8'h15);
        send_check("dffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00);
        send_check("d0000", 32'h00000000, 32'h00000000, 8'h00);
        send_check("d8000", 32'h80000000, 32'h80000000, 8'h8A);

        // Backpressure: two accepts fill the FIFO, the third word waits.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h00000001;
        @(negedge clk);
        check("bp_ready_1", 64'(in_ready), 64'd1);
        in_data = 32'h00010000;
        @(negedge clk);
        check("bp_ready_full", 64'(in_ready), 64'd0);
        in_data = 32'h80000000;
        @(negedge clk);
        check("bp_ready_hold", 64'(in_ready), 64'd0);
        check("bp_hold_data",  64'(out_data),  64'h00000001);
        check("bp_hold_check", 64'(out_check), 64'h51);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_w1_data",  64'(out_data),  64'h00010000);
        check("bp_w1_check", 64'(out_check), 64'h15);
        check("bp_ready_free", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_w2_data",  64'(out_data),  64'h80000000);
        check("bp_w2_check", 64'(out_check), 64'h8A);
        @(negedge clk);
        exp_cnt += 3;
        check("bp_empty", 64'(out_valid), 64'd0);
        check_cnt("bp_cnt");

        // Injection into data bit 5, check bit 1, and an out-of-range position.
        @(negedge clk);
        inj_arm = 1'b1; inj_pos = 6'd5;
        @(negedge clk);
        inj_arm = 1'b0;
        check("inj5_pending", 64'(inj_pending), 64'd1);
        send_check("inj5", 32'h0, 32'h00000020, 8'h00);
        check("inj5_cleared", 64'(inj_pending), 64'd0);

        @(negedge clk);
        inj_arm = 1'b1; inj_pos = 6'd33;
        @(negedge clk);
        inj_arm = 1'b0;
        send_check("inj33", 32'h0, 32'h00000000, 8'h02);

        @(negedge clk);
        inj_arm = 1'b1; inj_pos = 6'd45;
        @(negedge clk);
        inj_arm = 1'b0;
        check("inj45_ignored", 64'(inj_pending), 64'd0);
        send_check("inj45_clean", 32'h00000001, 32'h00000001, 8'h51);

        // Re-arm while armed: the latest position is used.
        @(negedge clk);
        inj_arm = 1'b1; inj_pos = 6'd2;
        @(negedge clk);
        inj_pos = 6'd39;
        @(negedge clk);
        inj_arm = 1'b0;
        send_check("rearm", 32'h0, 32'h00000000, 8'h80);

        // Arm and accept together while idle: this word is clean, the next is corrupted.
        @(negedge clk);
        inj_arm = 1'b1; inj_pos = 6'd0; in_valid = 1'b1; in_data = 32'h0;
        @(negedge clk);
        inj_arm = 1'b0; in_valid = 1'b0;
        check("same_clean", 64'(out_data), 64'h0);
        check("same_pending", 64'(inj_pending), 64'd1);
        @(negedge clk);
        exp_cnt++;
        send_check("same_next", 32'h0, 32'h00000001, 8'h00);

        // 100-word stream, no bubbles; word 51 carries an injected data error.
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k > 0) begin
                ent = exp_q.pop_front();
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_word", 64'({out_check, out_data}), 64'(ent[39:0]));
                check("stream_decoded", 64'(correct(out_data, out_check)), 64'(ent[71:40]));
                check("stream_ready", 64'(in_ready), 64'd1);
                check_cnt("stream_cnt");
                exp_cnt++;
            end
            if (k < 100) begin
                d  = 32'(k) * 32'h9E3779B9 + 32'h1234;
                ed = (k == 51) ? (d ^ (32'd1 << 13)) : d;
                in_valid = 1'b1;
                in_data  = d;
                inj_arm  = (k == 50);
                inj_pos  = 6'd13;
                exp_q.push_back({d, ref_check(d), ed});
            end else begin
                in_valid = 1'b0;
                inj_arm  = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_empty", 64'(out_valid), 64'd0);
        check_cnt("stream_wrap_cnt");

        // Reset with two words queued and an injection armed.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hAAAA5555;
        @(negedge clk);
        in_data = 32'h5555AAAA;
        @(negedge clk);
        in_valid = 1'b0;
        inj_arm = 1'b1; inj_pos = 6'd7;
        @(negedge clk);
        inj_arm = 1'b0;
        check("pre_rst_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",   64'(out_valid),   64'd0);
        check("mid_rst_ready",   64'(in_ready),    64'd1);
        check("mid_rst_cnt",     64'(word_cnt),    64'd0);
        check("mid_rst_pending", 64'(inj_pending), 64'd0);
        check("mid_rst_data",    64'(out_data),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_cnt = 0;
        send_check("post_rst", 32'h00010000, 32'h00010000, 8'h15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
